// File: rtl/scan_sample_mux_pkg.sv
// Shared types and constants for the scan/sample multiplexer.
package scan_sample_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_sample_mux_next_chan_find.sv
// Priority search for the lowest set mask bit strictly above idx_i,
// or the lowest set bit overall when from_start_i is high.
module scan_sample_mux_next_chan_find #(
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic [(2**SEL_WIDTH)-1:0] mask_i,
    input  logic [SEL_WIDTH-1:0]      idx_i,
    input  logic                      from_start_i,
    output logic                      found_c_o,
    output logic [SEL_WIDTH-1:0]      next_c_o
);

    localparam int unsigned N = 2**SEL_WIDTH;

    // Walk downwards so the lowest qualifying bit is the one left standing.
    always_comb begin
        found_c_o = 1'b0;
        next_c_o  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_start_i || (i > int'(idx_i)))) begin
                found_c_o = 1'b1;
                next_c_o  = SEL_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/scan_sample_mux.sv
// Registered channel sampler: settle wait, capture, valid/ready hold; manual or scan frames.
// Optional frame_end output enabled by defining SCAN_SAMPLE_MUX_FRAME_END_EN.
module scan_sample_mux
    import scan_sample_mux_pkg::*;
#(
    parameter int unsigned SEL_WIDTH    = 2,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned SETTLE_WIDTH = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      mode,
    input  logic [SEL_WIDTH-1:0]                      manual_sel,
    input  logic [(2**SEL_WIDTH)-1:0]                 chan_en,
    input  logic [SETTLE_WIDTH-1:0]                   settle_cycles,
    input  logic [(2**SEL_WIDTH)-1:0][DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0]                     out_data,
    output logic [SEL_WIDTH-1:0]                      out_chan,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      busy
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
    ,
    output logic                                      frame_end
`endif
);

    localparam int unsigned N     = 2**SEL_WIDTH;
    // One spare bit so settle + 1 never wraps at the maximum setting.
    localparam int unsigned CNT_W = SETTLE_WIDTH + 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
    logic                    mode_q, mode_d;
    logic [N-1:0]            en_q, en_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [SEL_WIDTH-1:0]    chan_q, chan_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
    logic                    fe_q, fe_d;
`endif

    logic                    find_from_start;
    logic [N-1:0]            find_mask;
    logic                    find_found;
    logic [SEL_WIDTH-1:0]    find_next;
    logic                    accept;
    logic                    settled;

    scan_sample_mux_next_chan_find #(
        .SEL_WIDTH(SEL_WIDTH)
    ) u_find (
        .mask_i      (find_mask),
        .idx_i       (sel_q),
        .from_start_i(find_from_start),
        .found_c_o   (find_found),
        .next_c_o    (find_next)
    );

    // Idle searches the live mask from the bottom; otherwise search the latched mask above sel.
    assign find_from_start = (state_q == IDLE);
    assign find_mask       = find_from_start ? chan_en : en_q;
    assign accept          = start && ((mode == MODE_MANUAL) || find_found);
    assign settled         = (cnt_q == ({1'b0, settle_q} + CNT_W'(1)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        mode_d   = mode_q;
        en_d     = en_q;
        sel_d    = sel_q;
        data_d   = data_q;
        chan_d   = chan_q;
        valid_d  = valid_q;
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
        fe_d     = fe_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d   = mode;
                    en_d     = chan_en;
                    settle_d = settle_cycles;
                    sel_d    = (mode == MODE_SCAN) ? find_next : manual_sel;
                    cnt_d    = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settled) begin
                    data_d  = in[sel_q];
                    chan_d  = sel_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
                    fe_d    = (mode_q == MODE_MANUAL) || !find_found;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
                    fe_d    = 1'b0;
`endif
                    if ((mode_q == MODE_SCAN) && find_found) begin
                        sel_d   = find_next;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            settle_q <= '0;
            mode_q   <= MODE_MANUAL;
            en_q     <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
            fe_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            mode_q   <= mode_d;
            en_q     <= en_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
            fe_q     <= fe_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
    assign frame_end = fe_q;
`endif

endmodule

// File: tb/tb_scan_sample_mux.sv
// Self-checking bench for scan_sample_mux: directed scenarios plus randomized frames vs. a sequence model.
module tb_scan_sample_mux;

    localparam int unsigned SW = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned TW = 4;
    localparam int unsigned N  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  mode;
    logic [SW-1:0]         manual_sel;
    logic [N-1:0]          chan_en;
    logic [TW-1:0]         settle_cycles;
    logic [N-1:0][DW-1:0]  in_bus;
    logic [DW-1:0]         out_data;
    logic [SW-1:0]         out_chan;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
    logic                  frame_end;
`endif

    int tests = 0;
    int fails = 0;

    scan_sample_mux #(
        .SEL_WIDTH(SW), .DATA_WIDTH(DW), .SETTLE_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .manual_sel(manual_sel), .chan_en(chan_en), .settle_cycles(settle_cycles),
        .in(in_bus), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
        , .frame_end(frame_end)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_plan_values();
        in_bus[0] = $realtobits(1.2);
        in_bus[1] = $realtobits(2.5);
        in_bus[2] = $realtobits(0.4);
        in_bus[3] = $realtobits(5.5);
    endtask

    // Drives one start pulse; returns just after the accepting edge.
    task automatic pulse_start(input logic m, input logic [SW-1:0] sel,
                               input logic [N-1:0] en, input logic [TW-1:0] st);
        mode = m; manual_sel = sel; chan_en = en; settle_cycles = st;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges until out_valid is seen; -1 when the bound expires.
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        tests++;
        if (out_data !== '0 || out_chan !== '0) begin
            fails++; $display("FAIL reset_data: data=%h chan=%0d expected 0 0", out_data, out_chan);
        end
    endtask

    task automatic test_manual();
        int n;
        set_plan_values();
        out_ready = 1'b1;
        pulse_start(1'b0, 2'd1, 4'b0000, 4'd0);
        wait_valid(n);
        tests++;
        if (n != 2) begin
            fails++; $display("FAIL manual_latency: got %0d edges expected 2", n);
        end
        tests++;
        if (out_chan !== 2'd1 || out_data !== $realtobits(2.5)) begin
            fails++; $display("FAIL manual_sample: chan=%0d data=%h expected 1 %h", out_chan, out_data, $realtobits(2.5));
        end
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
        tests++;
        if (frame_end !== 1'b1) begin
            fails++; $display("FAIL manual_frame_end: got %b expected 1", frame_end);
        end
`endif
        tick();
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL manual_release: busy=%b valid=%b expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_scan();
        int n;
        int exp_ch[3] = '{0, 1, 3};
        set_plan_values();
        out_ready = 1'b1;
        pulse_start(1'b1, 2'd2, 4'b1011, 4'd2);
        for (int k = 0; k < 3; k++) begin
            wait_valid(n);
            tests++;
            if (n != 4 || out_chan !== SW'(exp_ch[k]) || out_data !== in_bus[exp_ch[k]]) begin
                fails++;
                $display("FAIL scan_step%0d: edges=%0d chan=%0d data=%h expected 4 %0d %h",
                         k, n, out_chan, out_data, exp_ch[k], in_bus[exp_ch[k]]);
            end
            tick();
        end
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL scan_end: busy=%b valid=%b expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [DW-1:0] held_d;
        logic [SW-1:0] held_c;
        set_plan_values();
        out_ready = 1'b0;
        pulse_start(1'b1, 2'd0, 4'b1011, 4'd1);
        wait_valid(n);
        held_d = out_data; held_c = out_chan;
        tests++;
        if (n != 3 || held_c !== 2'd0 || held_d !== $realtobits(1.2)) begin
            fails++; $display("FAIL bp_first: edges=%0d chan=%0d data=%h expected 3 0 %h", n, held_c, held_d, $realtobits(1.2));
        end
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < int'(N); i++) in_bus[i] = {$urandom, $urandom};
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_chan !== held_c) begin
                fails++; $display("FAIL bp_hold%0d: valid=%b chan=%0d data=%h expected 1 %0d %h", c, out_valid, out_chan, out_data, held_c, held_d);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL bp_release: valid=%b busy=%b expected 0 1", out_valid, busy);
        end
        wait_valid(n);
        tests++;
        if (n != 3 || out_chan !== 2'd1 || out_data !== in_bus[1]) begin
            fails++; $display("FAIL bp_next: edges=%0d chan=%0d data=%h expected 3 1 %h", n, out_chan, out_data, in_bus[1]);
        end
        out_ready = 1'b1;
        tick();
        wait_valid(n);
        tick();
        out_ready = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL bp_drain: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_empty_scan();
        pulse_start(1'b1, 2'd0, 4'b0000, 4'd3);
        for (int c = 0; c < 6; c++) begin
            tests++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                fails++; $display("FAIL empty_scan%0d: busy=%b valid=%b expected 0 0", c, busy, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        set_plan_values();
        out_ready = 1'b1;
        pulse_start(1'b0, 2'd2, 4'b0000, 4'd3);
        tick();
        pulse_start(1'b1, 2'd0, 4'b1111, 4'd0);
        wait_valid(n);
        tests++;
        if (n != 3 || out_chan !== 2'd2 || out_data !== $realtobits(0.4)) begin
            fails++; $display("FAIL busy_start: edges=%0d chan=%0d data=%h expected 3 2 %h", n, out_chan, out_data, $realtobits(0.4));
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            tests++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                fails++; $display("FAIL busy_start_idle%0d: busy=%b valid=%b expected 0 0", c, busy, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        set_plan_values();
        out_ready = 1'b1;
        pulse_start(1'b1, 2'd0, 4'b1011, 4'd2);
        wait_valid(n);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_chan !== '0) begin
            fails++; $display("FAIL reset_mid: valid=%b busy=%b chan=%0d data=%h expected all 0", out_valid, busy, out_chan, out_data);
        end
        pulse_start(1'b0, 2'd3, 4'b0000, 4'd0);
        wait_valid(n);
        tests++;
        if (n != 2 || out_chan !== 2'd3 || out_data !== $realtobits(5.5)) begin
            fails++; $display("FAIL reset_mid_restart: edges=%0d chan=%0d data=%h expected 2 3 %h", n, out_chan, out_data, $realtobits(5.5));
        end
        tick();
    endtask

    task automatic test_settle_max();
        int n;
        set_plan_values();
        out_ready = 1'b1;
        pulse_start(1'b0, 2'd3, 4'b0000, 4'd15);
        wait_valid(n);
        tests++;
        if (n != 17 || out_chan !== 2'd3) begin
            fails++; $display("FAIL settle_max: edges=%0d chan=%0d expected 17 3", n, out_chan);
        end
        tick();
    endtask

`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
    task automatic test_frame_end();
        int n;
        set_plan_values();
        out_ready = 1'b1;
        pulse_start(1'b1, 2'd0, 4'b0110, 4'd0);
        wait_valid(n);
        tests++;
        if (out_chan !== 2'd1 || frame_end !== 1'b0) begin
            fails++; $display("FAIL fe_first: chan=%0d fe=%b expected 1 0", out_chan, frame_end);
        end
        tick();
        wait_valid(n);
        tests++;
        if (out_chan !== 2'd2 || frame_end !== 1'b1) begin
            fails++; $display("FAIL fe_last: chan=%0d fe=%b expected 2 1", out_chan, frame_end);
        end
        tick();
    endtask
`endif

    // Model: a manual start yields {sel}; a scan start yields every enabled channel ascending.
    task automatic test_random();
        int n;
        int exp_q[$];
        logic          m;
        logic [SW-1:0] sel;
        logic [N-1:0]  en;
        logic [TW-1:0] st;
        for (int it = 0; it < 40; it++) begin
            m   = 1'($urandom_range(0, 1));
            sel = SW'($urandom_range(0, 3));
            en  = N'($urandom_range(0, 15));
            st  = ($urandom_range(0, 7) == 0) ? 4'd15 : TW'($urandom_range(0, 4));
            for (int i = 0; i < int'(N); i++) in_bus[i] = {$urandom, $urandom};
            exp_q.delete();
            if (m == 1'b0) exp_q.push_back(int'(sel));
            else for (int i = 0; i < int'(N); i++) if (en[i]) exp_q.push_back(i);
            out_ready = 1'($urandom_range(0, 1));
            pulse_start(m, sel, en, st);
            mode = 1'($urandom_range(0, 1));
            manual_sel = SW'($urandom);
            chan_en = N'($urandom);
            settle_cycles = TW'($urandom);
            for (int k = 0; k < exp_q.size(); k++) begin
                wait_valid(n);
                tests++;
                if (n != int'(st) + 2 || out_chan !== SW'(exp_q[k]) || out_data !== in_bus[exp_q[k]]) begin
                    fails++;
                    $display("FAIL rand%0d_s%0d: edges=%0d chan=%0d data=%h expected %0d %0d %h",
                             it, k, n, out_chan, out_data, int'(st) + 2, exp_q[k], in_bus[exp_q[k]]);
                end
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
                tests++;
                if (frame_end !== (k == exp_q.size() - 1)) begin
                    fails++; $display("FAIL rand%0d_fe%0d: got %b expected %b", it, k, frame_end, (k == exp_q.size() - 1));
                end
`endif
                out_ready = 1'b0;
                for (int h = $urandom_range(0, 2); h > 0; h--) tick();
                out_ready = 1'b1;
                tick();
                out_ready = 1'($urandom_range(0, 1));
            end
            tick();
            tests++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                fails++; $display("FAIL rand%0d_end: busy=%b valid=%b expected 0 0", it, busy, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; manual_sel = '0;
        chan_en = '0; settle_cycles = '0; out_ready = 1'b0; in_bus = '0;
        test_reset();
        test_manual();
        test_scan();
        test_backpressure();
        test_empty_scan();
        test_start_while_busy();
        test_reset_mid();
        test_settle_max();
`ifdef SCAN_SAMPLE_MUX_FRAME_END_EN
        test_frame_end();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
